// File: rtl/hps_reset_requester.sv
// HPS reset requester: debounced cold/warm keys and a software handshake drive timed,
// active-low reset requests to the HPS. Define HPS_RST_STM_EVENTS_EN to build the STM event outputs.
module hps_reset_requester #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PULSE_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        key_cold_n,
    input  logic        key_warm_n,
    input  logic        sw_req_valid,
    output logic        sw_req_ready,
    input  logic [1:0]  sw_req_type,
    input  logic        h2f_reset_n,
    output logic        f2h_cold_reset_req_n,
    output logic        f2h_warm_reset_req_n,
    output logic        f2h_debug_reset_req_n,
    output logic [27:0] stm_hwevents,
    output logic        busy,
    output logic        timeout_err
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PULSE_W = $clog2(PULSE_CYCLES + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT_ENTER,
        S_WAIT_EXIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_COLD,
        K_WARM,
        K_DEBUG
    } kind_t;

    // Key index 0 is cold, index 1 is warm.
    logic [1:0]      w_key_raw;
    logic [1:0]      r_key_meta;
    logic [1:0]      r_key_sync;
    logic [1:0]      r_key_db;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [1:0]      r_pend;
    logic [1:0]      w_key_fall;
    logic [1:0]      w_take;

    logic r_h2f_meta;
    logic r_h2f_sync;

    state_t             r_state;
    state_t             w_state_next;
    kind_t              r_kind;
    kind_t              w_kind_next;
    logic               w_sel;
    logic               w_timeout;
    logic               w_in_wait;
    logic [PULSE_W-1:0] r_pulse_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_cold_req_n;
    logic               r_warm_req_n;
    logic               r_debug_req_n;
    logic               r_timeout_err;
    logic               r_armed;

    assign w_key_raw = {key_warm_n, key_cold_n};

    // A falling debounced edge is the cycle the debounce counter commits a 0.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_key_fall[k] = r_key_db[k] & ~r_key_sync[k] & (r_db_cnt[k] == DB_LAST);
        end
    end

    // NOTE: synchronizers and debounced levels reset to 1 so the idle-high keys
    // and h2f_reset_n do not look like a press or an HPS reset when reset releases.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_key_meta <= 2'b11;
            r_key_sync <= 2'b11;
            r_key_db   <= 2'b11;
            r_pend     <= 2'b00;
            r_h2f_meta <= 1'b1;
            r_h2f_sync <= 1'b1;
            for (int k = 0; k < 2; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge
            // value, which is what turns these two lines into a real two-stage chain.
            r_key_meta <= w_key_raw;
            r_key_sync <= r_key_meta;
            r_h2f_meta <= h2f_reset_n;
            r_h2f_sync <= r_h2f_meta;
            for (int k = 0; k < 2; k++) begin
                if (r_key_sync[k] != r_key_db[k]) begin
                    if (r_db_cnt[k] == DB_LAST) begin
                        r_key_db[k] <= r_key_sync[k];
                        r_db_cnt[k] <= '0;
                    end else begin
                        r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[k] <= '0;
                end
                // Starting the sequence wins, so a press landing while pending is absorbed.
                if (w_take[k]) begin
                    r_pend[k] <= 1'b0;
                end else if (w_key_fall[k]) begin
                    r_pend[k] <= 1'b1;
                end
            end
        end
    end

    assign w_in_wait    = (r_state == S_WAIT_ENTER) || (r_state == S_WAIT_EXIT);
    assign sw_req_ready = r_armed && (r_state == S_IDLE) && (r_pend == 2'b00);
    assign busy         = (r_state != S_IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_kind_next  = r_kind;
        w_take       = 2'b00;
        w_sel        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend[0]) begin
                    w_take[0]   = 1'b1;
                    w_sel       = 1'b1;
                    w_kind_next = K_COLD;
                end else if (r_pend[1]) begin
                    w_take[1]   = 1'b1;
                    w_sel       = 1'b1;
                    w_kind_next = K_WARM;
                end else if (sw_req_valid && sw_req_ready) begin
                    case (sw_req_type)
                        2'b01: begin
                            w_sel       = 1'b1;
                            w_kind_next = K_COLD;
                        end
                        2'b10: begin
                            w_sel       = 1'b1;
                            w_kind_next = K_WARM;
                        end
                        2'b11: begin
                            w_sel       = 1'b1;
                            w_kind_next = K_DEBUG;
                        end
                        default: w_sel = 1'b0;
                    endcase
                end
                if (w_sel) begin
                    w_state_next = S_ASSERT;
                end
            end
            S_ASSERT: begin
                // The debug request has no h2f handshake to wait for.
                if (r_pulse_cnt == PULSE_LAST) begin
                    w_state_next = (r_kind == K_DEBUG) ? S_DONE : S_WAIT_ENTER;
                end
            end
            S_WAIT_ENTER: begin
                if (!r_h2f_sync) begin
                    w_state_next = S_WAIT_EXIT;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next = S_DONE;
                    w_timeout    = 1'b1;
                end
            end
            S_WAIT_EXIT: begin
                if (r_h2f_sync) begin
                    w_state_next = S_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next = S_DONE;
                    w_timeout    = 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request outputs are registered from the next state so they cannot glitch.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state       <= S_IDLE;
            r_kind        <= K_COLD;
            r_pulse_cnt   <= '0;
            r_to_cnt      <= '0;
            r_cold_req_n  <= 1'b1;
            r_warm_req_n  <= 1'b1;
            r_debug_req_n <= 1'b1;
            r_timeout_err <= 1'b0;
            r_armed       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_kind        <= w_kind_next;
            r_armed       <= 1'b1;
            r_cold_req_n  <= !((w_state_next == S_ASSERT) && (w_kind_next == K_COLD));
            r_warm_req_n  <= !((w_state_next == S_ASSERT) && (w_kind_next == K_WARM));
            r_debug_req_n <= !((w_state_next == S_ASSERT) && (w_kind_next == K_DEBUG));
            if (r_state == S_ASSERT) begin
                r_pulse_cnt <= r_pulse_cnt + PULSE_W'(1);
            end else begin
                r_pulse_cnt <= '0;
            end
            if (w_in_wait && (w_state_next == r_state)) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if (w_sel) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign f2h_cold_reset_req_n  = r_cold_req_n;
    assign f2h_warm_reset_req_n  = r_warm_req_n;
    assign f2h_debug_reset_req_n = r_debug_req_n;
    assign timeout_err           = r_timeout_err;

`ifdef HPS_RST_STM_EVENTS_EN
    logic [15:0] r_seq_cnt;
    logic        r_to_pulse;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_seq_cnt  <= '0;
            r_to_pulse <= 1'b0;
        end else begin
            r_to_pulse <= w_timeout;
            if (r_state == S_DONE) begin
                r_seq_cnt <= r_seq_cnt + 16'd1;
            end
        end
    end

    assign stm_hwevents = {r_seq_cnt, 7'd0, r_to_pulse, ~r_h2f_sync,
                           ~r_debug_req_n, ~r_warm_req_n, ~r_cold_req_n};
`else
    assign stm_hwevents = '0;
`endif

endmodule

// File: doc/hps_reset_requester.md
HPS_RESET_REQUESTER -- requirements
Module: hps_reset_requester

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of stable cycles required before a key level is accepted.
REQ-002 SHALL have parameter PULSE_CYCLES, default 16, the low width of an issued reset request.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the per-wait-state limit for the HPS response.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk_clk in 1 (system clock); reset_reset in 1 (async, active-high).
REQ-005 SHALL have these ports:
- key_cold_n in 1: raw pushbutton, asynchronous, active-low.
- key_warm_n in 1: raw pushbutton, asynchronous, active-low.
- sw_req_valid in 1, sw_req_ready out 1, sw_req_type in 2: software request handshake; type 01 = cold, 10 = warm, 11 = debug, 00 = no-op.
- h2f_reset_n in 1: HPS-to-FPGA reset, asynchronous.
- f2h_cold_reset_req_n out 1, f2h_warm_reset_req_n out 1, f2h_debug_reset_req_n out 1: active-low reset requests to the HPS.
- stm_hwevents out 28: HPS STM hardware events.
- busy out 1: sequence in progress.
- timeout_err out 1: sticky error flag.

Function
REQ-006 SHALL pass key_cold_n, key_warm_n and h2f_reset_n through two-flop synchronizers before any use.
REQ-007 SHALL debounce each key with its own counter: the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter clears on any bounce.
REQ-008 SHALL set a per-key pending flag on each 1->0 transition of the debounced level; the flag clears when its sequence starts, and a repeat press while pending is absorbed.
REQ-009 SHALL drive sw_req_ready=1 only in IDLE with no key pending; a request is accepted on sw_req_valid&&sw_req_ready, and an accepted type 00 is consumed with no action.
REQ-010 SHALL choose the next sequence in IDLE by priority: cold pending > warm pending > software request.
REQ-011 SHALL implement FSM states IDLE, ASSERT, WAIT_ENTER, WAIT_EXIT, DONE.
REQ-012 IDLE->ASSERT on selection; the chosen request output goes low on the next cycle and stays low for exactly PULSE_CYCLES cycles; the other request outputs stay 1.
REQ-013 ASSERT->WAIT_ENTER for cold/warm; ASSERT->DONE for debug, since no h2f handshake is expected.
REQ-014 WAIT_ENTER->WAIT_EXIT when synchronized h2f_reset_n=0; WAIT_EXIT->DONE when it returns to 1.
REQ-015 Each wait state SHALL restart a timeout counter on entry; when it reaches TIMEOUT_CYCLES the FSM goes to DONE, timeout_err is set, and stm_hwevents[4] pulses for one cycle.
REQ-016 DONE SHALL last one cycle and then go to IDLE; busy=1 in every state except IDLE.
REQ-017 timeout_err SHALL clear on the cycle the next sequence is selected.
REQ-018 h2f_reset_n activity in IDLE (HPS-initiated reset) SHALL not move the FSM; it is reflected only in stm_hwevents[3].
REQ-019 Key presses during a sequence SHALL set pending flags and be served after DONE; software is held off by sw_req_ready=0.

Reset
REQ-020 Asserting reset_reset SHALL immediately return the FSM to IDLE and release all requests to 1 without waiting for a clock edge.
REQ-021 Reset values SHALL be:
- FSM = IDLE; sw_req_ready, busy, timeout_err, stm_hwevents = 0.
- Synchronizer flops and debounced levels = 1.
- Pending flags and counters = 0.
REQ-022 sw_req_ready SHALL rise on the first clock after reset_reset deasserts.

Configuration
REQ-023 With macro HPS_RST_STM_EVENTS_EN defined, stm_hwevents SHALL carry:
- [0]/[1]/[2]: the inverse of the cold/warm/debug request outputs.
- [3]: inverse of synchronized h2f_reset_n.
- [4]: timeout pulse.
- [11:5]: 0.
- [27:12]: a 16-bit count of completed sequences that increments in DONE and wraps from 0xFFFF to 0.
REQ-024 Without HPS_RST_STM_EVENTS_EN, stm_hwevents SHALL be constant 0 and the counter and event logic SHALL not be built.

Verification
REQ-025 Software type 10 accepted at cycle N, h2f_reset_n low at N+20 and high at N+40:
- warm_req_n low for cycles N+1..N+16; busy high until DONE.
- sw_req_ready back to 1 after DONE; count = 1.
REQ-026 key_cold_n bouncing 5 times within <DEBOUNCE_CYCLES, then held low: exactly one cold sequence starts, DEBOUNCE_CYCLES+2..3 cycles after the final edge.
REQ-027 Cold key pending and sw_req_valid (type 10) in the same IDLE cycle: cold sequence first, software request accepted after DONE.
REQ-028 Type 01 accepted with h2f_reset_n held at 1: timeout_err=1 and stm[4] pulses after TIMEOUT_CYCLES in WAIT_ENTER; the next accept clears timeout_err.
REQ-029 Type 11 accepted: debug_req_n low for 16 cycles, DONE next, h2f_reset_n ignored.
REQ-030 reset_reset asserted mid-ASSERT: request output returns to 1 within the same cycle; FSM = IDLE; stm = 0.
